// File: rtl/instr_mem_server_pkg.sv
// Shared types and constants for the instruction-memory server and its fetch-side users.
package instr_mem_server_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned COUNT_W = ADDR_W + 1;

    // A count byte of zero requests a full-memory load.
    localparam logic [COUNT_W-1:0] ZERO_COUNT_WORDS = COUNT_W'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLoadCnt,
        StLoadHi,
        StLoadLo,
        StWrite,
        StDone
    } state_e;

    function automatic logic [COUNT_W-1:0] count_from_byte(input logic [7:0] b);
        return (b == 8'd0) ? ZERO_COUNT_WORDS : {1'b0, b};
    endfunction

endpackage

// File: rtl/instr_mem_server_if.sv
// Fetch and program-load signals between the instruction-memory server and its clients.
interface instr_mem_server_if;
    import instr_mem_server_pkg::*;

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              busy;
    logic              load_start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              load_done;

    modport slave (
        input  fetch_req, fetch_addr, load_start, rx_valid, rx_data,
        output fetch_valid, fetch_data, busy, rx_ready, load_done
    );

    modport master (
        output fetch_req, fetch_addr, load_start, rx_valid, rx_data,
        input  fetch_valid, fetch_data, busy, rx_ready, load_done
    );

endinterface

// File: rtl/instr_mem_server_ram.sv
// Single-clock instruction RAM: synchronous write, registered read with one-cycle latency.
module instr_ram
    import instr_mem_server_pkg::*;
#(
    parameter int unsigned Depth = DEPTH,
    parameter int unsigned AddrW = ADDR_W,
    parameter int unsigned DataW = DATA_W
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/instr_mem_server.sv
// Instruction-memory responder: one-cycle fetch reads plus a byte-stream program loader.
module instr_mem_server
    import instr_mem_server_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    instr_mem_server_if.slave bus
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [7:0]         hi_q, hi_d;
    logic [7:0]         lo_q, lo_d;
    logic               fetch_valid_q;
    logic [DATA_W-1:0]  hold_q;
    logic               fetch_accept;
    logic               ram_we;
    logic               rx_fire;
    logic [DATA_W-1:0]  ram_rdata;

    assign bus.rx_ready  = (state_q == StLoadCnt) || (state_q == StLoadHi) ||
                           (state_q == StLoadLo);
    assign bus.busy      = (state_q != StIdle);
    assign bus.load_done = (state_q == StDone);
    assign rx_fire       = bus.rx_valid && bus.rx_ready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rem_d        = rem_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        ram_we       = 1'b0;
        fetch_accept = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A load request wins; the simultaneous fetch is dropped and retried later.
                if (bus.load_start) begin
                    state_d  = StLoadCnt;
                    wr_ptr_d = '0;
                end else if (bus.fetch_req) begin
                    fetch_accept = 1'b1;
                end
            end
            StLoadCnt: begin
                if (rx_fire) begin
                    rem_d   = count_from_byte(bus.rx_data);
                    state_d = StLoadHi;
                end
            end
            StLoadHi: begin
                if (rx_fire) begin
                    hi_d    = bus.rx_data;
                    state_d = StLoadLo;
                end
            end
            StLoadLo: begin
                if (rx_fire) begin
                    lo_d    = bus.rx_data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                rem_d    = rem_q - 1'b1;
                state_d  = (rem_q == COUNT_W'(1)) ? StDone : StLoadHi;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rem_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            fetch_valid_q <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rem_q         <= rem_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            fetch_valid_q <= fetch_accept;
            if (fetch_valid_q) begin
                hold_q <= ram_rdata;
            end
        end
    end

    // RAM output register is not reset, so fetch_data is muxed with a resettable hold copy.
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_valid_q ? ram_rdata : hold_q;

    instr_ram #(
        .Depth (DEPTH),
        .AddrW (ADDR_W),
        .DataW (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({hi_q, lo_q}),
        .re_i    (fetch_accept),
        .raddr_i (bus.fetch_addr),
        .rdata_o (ram_rdata)
    );

endmodule
